// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sd_pkg
// Description : Shared types and constants for the sum/difference unit.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_pkg;

  // Operation select; the encoding doubles as the adder carry-in.
  typedef enum logic {
    OP_SUM  = 1'b0,
    OP_DIFF = 1'b1
  } op_e;

  localparam int DEFAULT_WIDTH = 4;

endpackage : sd_pkg
`default_nettype wire

// File: rtl/rca_adder.sv
`default_nettype none
// ============================================================================
// Module      : rca_adder
// Description : WIDTH-bit ripple-carry adder built from full-adder cells,
//               with carry-out and two's-complement overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  // Carry chain: entry 0 is the carry-in, entry WIDTH is the carry-out.
  logic [WIDTH:0] w_carry;

  assign w_carry[0] = cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign sum[gi]          = a[gi] ^ b[gi] ^ w_carry[gi];
      assign w_carry[gi + 1]  = (a[gi] & b[gi]) | (a[gi] & w_carry[gi]) | (b[gi] & w_carry[gi]);
    end
  endgenerate

  assign cout = w_carry[WIDTH];

  // Overflow: both addends share a sign and the result sign differs from it.
  assign ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule : rca_adder
`default_nettype wire

// File: rtl/sum_diff_unit.sv
`default_nettype none
// ============================================================================
// Module      : sum_diff_unit
// Description : Registered adder/subtractor. check=0 gives n1+n2, check=1
//               gives n1-n2 (modulo 2^WIDTH) with carry and signed-overflow
//               flags, one cycle after a valid input.
// Revision    : 1.0 - initial release
// ============================================================================
module sum_diff_unit
  import sd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] n1,
  input  logic [WIDTH-1:0] n2,
  input  logic             check,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf
);

  op_e              w_op;
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] out_d, out_q;
  logic             cout_d, cout_q;
  logic             ovf_d, ovf_q;

  // Subtraction is addition of the inverted operand with a carry-in of one.
  always_comb begin
    w_op  = op_e'(check);
    w_b   = n2 ^ {WIDTH{w_op == OP_DIFF}};
    w_cin = (w_op == OP_DIFF);
  end

  rca_adder #(
    .WIDTH (WIDTH)
  ) u_rca_adder (
    .a    (n1),
    .b    (w_b),
    .cin  (w_cin),
    .sum  (w_sum),
    .cout (w_cout),
    .ovf  (w_ovf)
  );

  // Capture a new result on valid input; otherwise hold the last result.
  always_comb begin
    out_valid_d = in_valid;
    out_d       = out_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (in_valid) begin
      out_d  = w_sum;
      cout_d = w_cout;
      ovf_d  = w_ovf;
    end
  end

  // Output registers with synchronous reset taking priority over valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule : sum_diff_unit
`default_nettype wire

// File: tb/tb_sum_diff_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_sum_diff_unit
// Description : Self-checking bench for sum_diff_unit (WIDTH = 4) using an
//               integer-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_diff_unit;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] n1;
  logic [W-1:0] n2;
  logic         check;
  logic         out_valid;
  logic [W-1:0] out;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference-model state: what the outputs should show after each edge.
  logic         e_valid;
  logic [W-1:0] e_out;
  logic         e_cout;
  logic         e_ovf;

  always #5 clk = ~clk;

  sum_diff_unit #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .n1        (n1),
    .n2        (n2),
    .check     (check),
    .out_valid (out_valid),
    .out       (out),
    .cout      (cout),
    .ovf       (ovf)
  );

  function automatic int to_signed(input int u);
    return (u >= MOD / 2) ? u - MOD : u;
  endfunction

  // Model of one clock edge, from plain integer arithmetic.
  function automatic void model(input logic r, input logic v, input int a, input int b, input logic c);
    int raw, sr;
    if (r) begin
      e_valid = 1'b0;
      e_out   = '0;
      e_cout  = 1'b0;
      e_ovf   = 1'b0;
    end else if (v) begin
      raw     = c ? (a - b) : (a + b);
      e_out   = W'(((raw % MOD) + MOD) % MOD);
      e_cout  = c ? (a >= b) : (a + b >= MOD);
      sr      = c ? (to_signed(a) - to_signed(b)) : (to_signed(a) + to_signed(b));
      e_ovf   = (sr > MOD / 2 - 1) || (sr < -(MOD / 2));
      e_valid = 1'b1;
    end else begin
      e_valid = 1'b0;
    end
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, advance an edge, then compare against the model.
  task automatic step(input string tag, input logic r, input logic v, input int a, input int b, input logic c);
    rst      = r;
    in_valid = v;
    n1       = W'(a);
    n2       = W'(b);
    check    = c;
    @(posedge clk);
    model(r, v, a, b, c);
    #1;
    cmp({tag, "_valid"}, 32'(out_valid), 32'(e_valid));
    cmp({tag, "_out"},   32'(out),       32'(e_out));
    cmp({tag, "_cout"},  32'(cout),      32'(e_cout));
    cmp({tag, "_ovf"},   32'(ovf),       32'(e_ovf));
  endtask

  initial begin
    int sweep_exp [9] = '{1, 1, 5, 1, 9, 1, 13, 1, 1};
    logic [W-1:0] held;

    rst = 1'b1; in_valid = 1'b0; n1 = '0; n2 = '0; check = 1'b0;
    e_valid = 1'b0; e_out = '0; e_cout = 1'b0; e_ovf = 1'b0;

    // Reset then idle.
    step("reset0", 1'b1, 1'b0, 0, 0, 1'b0);
    step("reset1", 1'b1, 1'b0, 0, 0, 1'b0);
    cmp("reset_out_zero", 32'(out), 32'd0);
    step("idle0", 1'b0, 1'b0, 5, 3, 1'b0);
    step("idle1", 1'b0, 1'b0, 9, 2, 1'b1);

    // Sweep: n1 = i, n2 = i-1, difference on even i.
    for (int i = 1; i <= 9; i++) begin
      step($sformatf("sweep%0d", i), 1'b0, 1'b1, i, i - 1, (i % 2) == 0);
      cmp($sformatf("sweep%0d_literal", i), 32'(out), 32'(sweep_exp[i - 1]));
    end
    cmp("sweep9_cout_literal", 32'(cout), 32'd1);

    // Borrow cases.
    step("borrow_3m5", 1'b0, 1'b1, 3, 5, 1'b1);
    cmp("borrow_3m5_literal", {27'd0, out, cout}, {27'd0, 4'd14, 1'b0});
    step("borrow_5m5", 1'b0, 1'b1, 5, 5, 1'b1);
    cmp("borrow_5m5_literal", {27'd0, out, cout}, {27'd0, 4'd0, 1'b1});

    // Signed overflow cases.
    step("ovf_7p1", 1'b0, 1'b1, 7, 1, 1'b0);
    cmp("ovf_7p1_literal", {26'd0, out, cout, ovf}, {26'd0, 4'd8, 1'b0, 1'b1});
    step("ovf_8m1", 1'b0, 1'b1, 8, 1, 1'b1);
    cmp("ovf_8m1_literal", {26'd0, out, cout, ovf}, {26'd0, 4'd7, 1'b1, 1'b1});

    // Reset on the same edge as a valid input discards it.
    step("rst_mid", 1'b1, 1'b1, 4, 4, 1'b0);
    step("rst_rel", 1'b0, 1'b0, 0, 0, 1'b0);
    step("after_rst", 1'b0, 1'b1, 2, 2, 1'b0);
    cmp("after_rst_literal", 32'(out), 32'd4);

    // Back-to-back throughput, then hold.
    step("tp0", 1'b0, 1'b1, 15, 15, 1'b0);
    step("tp1", 1'b0, 1'b1, 0, 1, 1'b1);
    step("tp2", 1'b0, 1'b1, 6, 9, 1'b0);
    step("tp3", 1'b0, 1'b1, 12, 4, 1'b1);
    held = out;
    step("hold", 1'b0, 1'b0, 1, 1, 1'b0);
    cmp("hold_out_unchanged", 32'(out), 32'(held));

    // Randomised traffic with occasional idle cycles and resets.
    for (int k = 0; k < 60; k++) begin
      step($sformatf("rnd%0d", k),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, MOD - 1)),
           int'($urandom_range(0, MOD - 1)),
           1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sum_diff_unit
`default_nettype wire
